// File: rtl/regarb_pkg.sv
// Package: regarb_pkg
// Purpose: Shared definitions for the register-file write arbiter: FSM state
//          encoding, default geometry constants and the saturating increment
//          used by the optional grant statistics.
// Ports:   none (package)
package regarb_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_NREGS  = 8;
    localparam int STAT_W     = 16;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Module: rr_arbiter
// Purpose: Combinational round-robin pick. Searches valid_i starting at
//          ptr_i+1 (mod NREQ) and returns the first hit as one-hot and index.
// Ports:
//   valid_i [NREQ]   request vector
//   ptr_i   [IDX_W]  index granted last time (lowest priority now)
//   grant_o [NREQ]   one-hot grant, all-zero when nothing is valid
//   idx_o   [IDX_W]  index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [NREQ-1:0] rot_s;
    logic [IDX_W:0]  sum_s;

    // Rotate the doubled request vector so bit 0 is the highest-priority
    // requester, then keep the lowest set bit (loop runs high to low, last hit wins).
    always_comb begin
        rot_s   = NREQ'({valid_i, valid_i} >> ({1'b0, ptr_i} + {{IDX_W{1'b0}}, 1'b1}));
        grant_o = '0;
        idx_o   = '0;
        sum_s   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                sum_s = {1'b0, ptr_i} + (IDX_W+1)'(j + 1);
                if (sum_s >= (IDX_W+1)'(NREQ)) begin
                    sum_s = sum_s - (IDX_W+1)'(NREQ);
                end else begin
                    sum_s = sum_s;
                end
                idx_o   = sum_s[IDX_W-1:0];
                grant_o = {{(NREQ-1){1'b0}}, 1'b1} << idx_o;
            end else begin
                sum_s = sum_s;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Module: reg_write_arbiter
// Purpose: Shares the register file's single write port between NREQ
//          writeback requesters (round-robin, valid/ready) and sequences a
//          software clear that writes zero to every register, one per cycle.
// Optional feature: define REGARB_STATS_EN to add per-requester saturating
//          grant counters readable through STAT_SEL / STAT_COUNT.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   REQ_VALID/REQ_READY   per-requester handshake (READY one-hot, combinational)
//   REQ_ADDR/REQ_DATA     packed per-requester address/data slices
//   CLEAR_START           pulse: start the clear sequence
//   CLEAR_BUSY/CLEAR_DONE clear running / one-cycle completion pulse
//   WRITE/INADDRESS/IN    registered reg_file write port
//   STAT_SEL/STAT_COUNT   (REGARB_STATS_EN only) counter select / value
module reg_write_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NREQ-1:0]        REQ_VALID,
    output logic [NREQ-1:0]        REQ_READY,
    input  logic [NREQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NREQ*DATA_W-1:0] REQ_DATA,
    input  logic                   CLEAR_START,
    output logic                   CLEAR_BUSY,
    output logic                   CLEAR_DONE,
    output logic                   WRITE,
    output logic [ADDR_W-1:0]      INADDRESS,
    output logic [DATA_W-1:0]      IN
`ifdef REGARB_STATS_EN
    ,
    input  logic [$clog2(NREQ)-1:0] STAT_SEL,
    output logic [STAT_W-1:0]       STAT_COUNT
`endif
);

    localparam int IDX_W = $clog2(NREQ);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d, cnt_inc_s;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;

    logic [NREQ-1:0]     grant_s, ready_s;
    logic [IDX_W-1:0]    gidx_s;
    logic                hs_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .valid_i (REQ_VALID),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (gidx_s)
    );

    // Grants only in RUN; a same-cycle clear request (or reset) suppresses them.
    always_comb begin
        ready_s    = (state_q == ST_RUN && !CLEAR_START && !RESET) ? grant_s : '0;
        hs_s       = |(REQ_VALID & ready_s);
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s = sel_addr_s | (REQ_ADDR[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[i]}});
            sel_data_s = sel_data_s | (REQ_DATA[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
        end
    end

    // Next-state and next-output logic. The clear counter mirrors the address
    // being issued, so its wrap to zero marks the last register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        write_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        cnt_inc_s = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        case (state_q)
            ST_RUN: begin
                if (CLEAR_START) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    write_d = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                end else if (hs_s) begin
                    write_d  = 1'b1;
                    addr_d   = sel_addr_s;
                    data_d   = sel_data_s;
                    rr_ptr_d = gidx_s;
                end else begin
                    write_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt_inc_s == '0) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc_s;
                    write_d = 1'b1;
                    addr_d  = cnt_inc_s;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            rr_ptr_q <= IDX_W'(NREQ - 1);
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign REQ_READY  = ready_s;
    assign CLEAR_BUSY = (state_q == ST_CLEAR);
    assign CLEAR_DONE = done_q;
    assign WRITE      = write_q;
    assign INADDRESS  = addr_q;
    assign IN         = data_q;

`ifdef REGARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NREQ];

    // Per-requester grant counters; only reset clears them, clear sequences do not.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (REQ_VALID[i] && ready_s[i]) begin
                    stat_q[i] <= sat_inc(stat_q[i]);
                end else begin
                    stat_q[i] <= stat_q[i];
                end
            end
        end
    end

    // Counter readback; out-of-range selects read as zero.
    always_comb begin
        STAT_COUNT = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (STAT_SEL == IDX_W'(i)) begin
                STAT_COUNT = stat_q[i];
            end else begin
                STAT_COUNT = STAT_COUNT;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level reference model.
module tb_reg_write_arbiter;

    localparam int NREQ   = 2;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    logic                   CLK = 1'b0;
    logic                   RESET;
    logic [NREQ-1:0]        REQ_VALID;
    logic [NREQ-1:0]        REQ_READY;
    logic [NREQ*ADDR_W-1:0] REQ_ADDR;
    logic [NREQ*DATA_W-1:0] REQ_DATA;
    logic                   CLEAR_START;
    logic                   CLEAR_BUSY;
    logic                   CLEAR_DONE;
    logic                   WRITE;
    logic [ADDR_W-1:0]      INADDRESS;
    logic [DATA_W-1:0]      IN;
`ifdef REGARB_STATS_EN
    logic [0:0]             STAT_SEL;
    logic [15:0]            STAT_COUNT;
`endif

    reg_write_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_DATA    (REQ_DATA),
        .CLEAR_START (CLEAR_START),
        .CLEAR_BUSY  (CLEAR_BUSY),
        .CLEAR_DONE  (CLEAR_DONE),
        .WRITE       (WRITE),
        .INADDRESS   (INADDRESS),
        .IN          (IN)
`ifdef REGARB_STATS_EN
        ,
        .STAT_SEL    (STAT_SEL),
        .STAT_COUNT  (STAT_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: expected registered outputs for the current cycle,
    // the remaining clear addresses, the last granted requester and grant tallies.
    int          last_g = NREQ - 1;
    int          clr_q[$];
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_write = 1'b0;
    int unsigned m_addr  = 0;
    int unsigned m_data  = 0;
    int unsigned m_cnt[NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check READY before the edge, advance the model, check outputs after it.
    task automatic cycle(output int g);
        logic [NREQ-1:0] exp_rdy;
        #1;
        g = -1;
        if (!RESET && !m_busy && !CLEAR_START) begin
            for (int off = 1; off <= NREQ; off++) begin
                int c;
                c = (last_g + off) % NREQ;
                if (g < 0 && REQ_VALID[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", 32'(REQ_READY), 32'(exp_rdy));
        @(posedge CLK);
        if (RESET) begin
            m_write = 1'b0; m_addr = 0; m_data = 0; m_busy = 1'b0; m_done = 1'b0;
            last_g = NREQ - 1;
            clr_q.delete();
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else if (m_busy) begin
            if (clr_q.size() > 0) begin
                m_addr = clr_q.pop_front(); m_data = 0; m_write = 1'b1; m_done = 1'b0;
            end else begin
                m_busy = 1'b0; m_done = 1'b1; m_write = 1'b0;
            end
        end else if (CLEAR_START) begin
            m_busy = 1'b1; m_write = 1'b1; m_addr = 0; m_data = 0; m_done = 1'b0;
            for (int k = 1; k < NREGS; k++) clr_q.push_back(k);
        end else begin
            m_done = 1'b0;
            if (g >= 0) begin
                m_write = 1'b1;
                m_addr  = 32'(REQ_ADDR[g*ADDR_W +: ADDR_W]);
                m_data  = 32'(REQ_DATA[g*DATA_W +: DATA_W]);
                last_g  = g;
                if (m_cnt[g] < 32'd65535) m_cnt[g]++;
            end else begin
                m_write = 1'b0;
            end
        end
        #1;
        chk("write", 32'(WRITE), 32'(m_write));
        chk("inaddress", 32'(INADDRESS), m_addr);
        chk("in", 32'(IN), m_data);
        chk("busy", 32'(CLEAR_BUSY), 32'(m_busy));
        chk("done", 32'(CLEAR_DONE), 32'(m_done));
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int d);
        REQ_VALID[i] = v;
        REQ_ADDR[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        REQ_DATA[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    initial begin
        int g;
        int seen_done;
        REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; CLEAR_START = 1'b0; RESET = 1'b1;
`ifdef REGARB_STATS_EN
        STAT_SEL = 1'b0;
`endif
        cycle(g); cycle(g);
        RESET = 1'b0;
        chk("rst_write", 32'(WRITE), 32'd0);
        chk("rst_addr", 32'(INADDRESS), 32'd0);
        chk("rst_busy", 32'(CLEAR_BUSY), 32'd0);

        // Single write from requester 0.
        set_req(0, 1'b1, 2, 95);
        cycle(g);
        chk("t1_grant", 32'(g), 32'd0);
        chk("t1_addr", 32'(INADDRESS), 32'd2);
        chk("t1_data", 32'(IN), 32'd95);
        REQ_VALID[0] = 1'b0;
        cycle(g);
        chk("t1_idle_write", 32'(WRITE), 32'd0);
        chk("t1_hold_addr", 32'(INADDRESS), 32'd2);

        // Both requesters continuously valid: grants alternate, WRITE stays high.
        set_req(0, 1'b1, 1, 28);
        set_req(1, 1'b1, 4, 6);
        for (int k = 0; k < 6; k++) begin
            cycle(g);
            chk("t2_alt", 32'(g), 32'((k + 1) % 2));
            chk("t2_write", 32'(WRITE), 32'd1);
        end

        // Clear with requester 1 pending; it must be served once the clear ends.
        REQ_VALID = 2'b10;
        CLEAR_START = 1'b1;
        cycle(g);
        CLEAR_START = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(g);
            if (CLEAR_DONE) seen_done++;
            if (g >= 0) REQ_VALID[g] = 1'b0;
        end
        chk("t3_done_once", 32'(seen_done), 32'd1);
        chk("t3_req1_served", 32'(REQ_VALID), 32'd0);

        // Reset on the fourth clear cycle.
        CLEAR_START = 1'b1;
        cycle(g);
        CLEAR_START = 1'b0;
        cycle(g); cycle(g);
        RESET = 1'b1;
        cycle(g);
        RESET = 1'b0;
        chk("t4_write", 32'(WRITE), 32'd0);
        chk("t4_addr", 32'(INADDRESS), 32'd0);
        chk("t4_busy", 32'(CLEAR_BUSY), 32'd0);
        for (int k = 0; k < 10; k++) cycle(g);

        // Requester 0 held while requester 1 is served first.
        set_req(1, 1'b1, 5, 200);
        cycle(g);
        set_req(0, 1'b1, 3, 77);
        for (int k = 0; k < 3; k++) begin
            cycle(g);
            if (g >= 0) REQ_VALID[g] = 1'b0;
        end
        chk("t5_all_served", 32'(REQ_VALID), 32'd0);

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 1500; n++) begin
            cycle(g);
            for (int i = 0; i < NREQ; i++) begin
                if (g == i) REQ_VALID[i] = 1'b0;
                if (!REQ_VALID[i] && $urandom_range(0, 2) != 0) begin
                    REQ_VALID[i] = 1'b1;
                    REQ_ADDR[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                    REQ_DATA[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
            CLEAR_START = ($urandom_range(0, 49) == 0);
            RESET       = ($urandom_range(0, 299) == 0);
        end
        CLEAR_START = 1'b0;
        RESET = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle(g);
            if (g >= 0) REQ_VALID[g] = 1'b0;
        end

`ifdef REGARB_STATS_EN
        // Saturate requester 0's counter.
        REQ_VALID = 2'b01;
        for (int n = 0; n < 70000; n++) cycle(g);
        REQ_VALID = '0;
        STAT_SEL = 1'b0;
        #1;
        chk("stat0_sat", 32'(STAT_COUNT), 32'h0000FFFF);
        STAT_SEL = 1'b1;
        #1;
        chk("stat1", 32'(STAT_COUNT), m_cnt[1]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
